// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter feeding a single UART TX byte stream.
// Whole packets are granted atomically; a stalled owner is released after IDLE_TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
   parameter int unsigned CLK_FREQ_HZ      = 72_000_000,
   parameter int unsigned IDLE_TIMEOUT_CYC = CLK_FREQ_HZ / 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s0_data,
   input  logic       s0_valid,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic [7:0] s1_data,
   input  logic       s1_valid,
   input  logic       s1_last,
   output logic       s1_ready,
   input  logic       lock0,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [1:0] grant,
   output logic       timeout
);

   localparam int unsigned CNT_W = (IDLE_TIMEOUT_CYC < 1) ? 1 : $clog2(IDLE_TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT_CYC);

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rr_q, rr_d;          // last requester granted (1 = req1)

   logic             out_ready;
   logic             xfer;
   logic [7:0]       xfer_data;
   logic             xfer_last;
   logic [CNT_W-1:0] cnt_inc;

   // Ready and transfer decode
   always_comb begin
      s0_ready  = 1'b0;
      s1_ready  = 1'b0;
      out_ready = !m_valid_q || m_ready;
      if (!rst) begin
         case (state_q)
            GRANT0:  s0_ready = out_ready;
            GRANT1:  s1_ready = out_ready;
            default: ;
         endcase
      end
      xfer      = (s0_valid && s0_ready) || (s1_valid && s1_ready);
      xfer_data = s0_ready ? s0_data : s1_data;
      xfer_last = s0_ready ? s0_last : s1_last;
   end

   // Next state, stall counter and output register
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      rr_d      = rr_q;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

      if (xfer) begin
         m_data_d  = xfer_data;
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (lock0) begin
               if (s0_valid) begin
                  state_d = GRANT0;
                  rr_d    = 1'b0;
               end
            end else if (s0_valid && s1_valid) begin
               state_d = rr_q ? GRANT0 : GRANT1;
               rr_d    = !rr_q;
            end else if (s0_valid) begin
               state_d = GRANT0;
               rr_d    = 1'b0;
            end else if (s1_valid) begin
               state_d = GRANT1;
               rr_d    = 1'b1;
            end
         end
         GRANT0, GRANT1: begin
            if (xfer) begin
               cnt_d = '0;
               if (xfer_last) state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  state_d   = IDLE;
                  timeout_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      if (rst) begin
         state_q   <= IDLE;
         m_data_q  <= 8'h00;
         m_valid_q <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         rr_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
      end
   end

   assign grant   = state_q;
   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: directed packets, lock, stall, timeout and reset cases.
// Expected byte order is pushed by the stimulus; a negedge monitor pops on every m_valid && m_ready.
module tb_uart_tx_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] s0_data, s1_data;
   logic       s0_valid, s0_last, s0_ready;
   logic       s1_valid, s1_last, s1_ready;
   logic       lock0;
   logic [7:0] m_data;
   logic       m_valid, m_ready;
   logic [1:0] grant;
   logic       timeout;

   int         n_vec  = 0;
   int         n_miss = 0;
   int         cyc    = 0;

   logic [7:0] exp_q[$];
   logic [1:0] hist[$];
   logic [1:0] hist_last = 2'b00;
   int         to_count = 0;
   int         to_cyc = 0;
   logic [1:0] to_grant = 2'b11;
   int         s1_xfer_cyc = 0;
   logic       prev_to = 1'b0;
   logic       hold_prev = 1'b0;
   logic [7:0] hold_data = 8'h00;

   uart_tx_arbiter #(
      .IDLE_TIMEOUT_CYC(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s0_data  (s0_data),
      .s0_valid (s0_valid),
      .s0_last  (s0_last),
      .s0_ready (s0_ready),
      .s1_data  (s1_data),
      .s1_valid (s1_valid),
      .s1_last  (s1_last),
      .s1_ready (s1_ready),
      .lock0    (lock0),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .grant    (grant),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input int id, input logic [7:0] d, input logic l, input logic v);
      if (id == 0) begin
         s0_data = d; s0_last = l; s0_valid = v;
      end else begin
         s1_data = d; s1_last = l; s1_valid = v;
      end
   endtask

   // Sends bytes[8*i+:8] for i < n_send; last flags byte n-1.
   task automatic send_pkt(input int id, input logic [31:0] bytes, input int n,
                           input int n_send, input int max_wait);
      logic acc;
      int   waited;
      for (int i = 0; i < n_send; i++) begin
         drive(id, bytes[8*i +: 8], (i == n - 1), 1'b1);
         waited = 0;
         do begin
            @(negedge clk);
            acc = (id == 0) ? s0_ready : s1_ready;
            @(posedge clk); #1;
            waited++;
         end while (!acc && waited < max_wait);
         if (!acc) begin
            n_vec++;
            n_miss++;
            $display("FAIL handshake_s%0d: byte %0d not accepted within %0d cycles", id, i, max_wait);
            break;
         end
      end
      drive(id, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic expect_pkt(input logic [31:0] bytes, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(bytes[8*i +: 8]);
   endtask

   // Grant sequence packed two bits per entry, first entry in the low bits.
   task automatic check_hist(input string name, input logic [15:0] seq, input int n);
      check({name, "_len"}, hist.size(), n);
      for (int i = 0; i < n && i < hist.size(); i++) check(name, hist[i], seq[2*i +: 2]);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Output monitor
   always @(negedge clk) begin
      if (timeout) begin
         to_count++;
         to_cyc   = cyc;
         to_grant = grant;
         if (prev_to) check("timeout_width", 32'd2, 32'd1);
      end
      prev_to = timeout;
      if (s1_valid && s1_ready) s1_xfer_cyc = cyc;
      if (grant != hist_last) begin
         hist.push_back(grant);
         hist_last = grant;
      end
      if (hold_prev) begin
         check("m_hold_data", m_data, hold_data);
         check("m_hold_valid", m_valid, 1);
      end
      hold_prev = m_valid && !m_ready && !rst;
      hold_data = m_data;
      if (m_valid && m_ready && !rst) begin
         if (exp_q.size() == 0) check("unexpected_byte", m_data, 32'hFFFF_FFFF);
         else check("m_data_order", m_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  to0;
      logic found;
      rst = 1'b1; lock0 = 1'b0; m_ready = 1'b1;
      drive(0, 8'h00, 1'b0, 1'b0);
      drive(1, 8'h00, 1'b0, 1'b0);

      // Reset state
      @(negedge clk);
      check("rst_s0_ready", s0_ready, 0);
      check("rst_s1_ready", s1_ready, 0);
      tick(); tick();
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_timeout", timeout, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_s0_ready", s0_ready, 0);
      check("post_rst_s1_ready", s1_ready, 0);
      tick();

      // Tie after reset: s0 packet 2E 30 00 first, then s1
      hist.delete();
      expect_pkt(32'h0000_302E, 3);
      expect_pkt(32'h0000_4241, 2);
      fork
         send_pkt(0, 32'h0000_302E, 3, 3, 50);
         send_pkt(1, 32'h0000_4241, 2, 2, 50);
      join
      repeat (4) tick();
      check_hist("tie_grant", 16'h0021, 4);
      check("tie_drained", exp_q.size(), 0);

      // Two consecutive ties: grants alternate 01, 10, 01
      hist.delete();
      expect_pkt(32'h0000_A2A1, 2);
      expect_pkt(32'h0000_C2C1, 2);
      expect_pkt(32'h0000_00B1, 1);
      expect_pkt(32'h0000_00D1, 1);
      fork
         begin
            send_pkt(0, 32'h0000_A2A1, 2, 2, 50);
            send_pkt(0, 32'h0000_00B1, 1, 1, 50);
         end
         begin
            send_pkt(1, 32'h0000_C2C1, 2, 2, 50);
            send_pkt(1, 32'h0000_00D1, 1, 1, 50);
         end
      join
      repeat (4) tick();
      check_hist("rr_grant", 16'h2121, 8);

      // lock0 holds s1 off for 100 cycles; s0 granted the cycle after it asks
      lock0 = 1'b1;
      expect_pkt(32'h0000_005C, 1);
      expect_pkt(32'h0000_E2E1, 2);
      fork
         send_pkt(1, 32'h0000_E2E1, 2, 2, 500);
         begin
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               check("lock_grant_idle", grant, 0);
               check("lock_s1_ready", s1_ready, 0);
               tick();
            end
            fork
               send_pkt(0, 32'h0000_005C, 1, 1, 50);
               begin
                  @(negedge clk);
                  check("lock_grant_pre", grant, 0);
                  @(negedge clk);
                  check("lock_grant0_next", grant, 2'b01);
               end
            join
            repeat (3) begin
               @(negedge clk);
               check("lock_after_s0_grant", grant, 0);
               tick();
            end
            lock0 = 1'b0;
         end
      join
      repeat (4) tick();

      // Output stall for 20 cycles mid-packet: data held, one timeout, no loss
      expect_pkt(32'h1413_1211, 4);
      fork
         send_pkt(0, 32'h1413_1211, 4, 4, 100);
         begin
            found = 1'b0;
            for (int k = 0; k < 50; k++) begin
               @(negedge clk);
               if (m_valid && m_data == 8'h11) begin
                  found = 1'b1;
                  break;
               end
            end
            check("stall_sync", found, 1);
            tick();
            m_ready = 1'b0;
            to0 = to_count;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               check("stall_s0_ready", s0_ready, 0);
               check("stall_m_data", m_data, 8'h12);
               tick();
            end
            check("stall_timeout_count", to_count - to0, 1);
            m_ready = 1'b1;
         end
      join
      repeat (4) tick();

      // s1 stalls after 2 of 4 bytes; timeout frees the grant for pending s0
      hist.delete();
      to0 = to_count;
      expect_pkt(32'h0000_7271, 2);
      expect_pkt(32'h0000_8281, 2);
      fork
         send_pkt(1, 32'h7473_7271, 4, 2, 50);
         begin
            repeat (3) tick();
            send_pkt(0, 32'h0000_8281, 2, 2, 100);
         end
      join
      repeat (4) tick();
      check("to_count", to_count - to0, 1);
      // timeout is high 16 clocks after the edge that accepted the last s1 byte
      check("to_delay", to_cyc - s1_xfer_cyc, 17);
      check("to_grant", to_grant, 0);
      check_hist("to_grant_seq", 16'h0012, 4);

      // Reset while a byte is held on the output
      m_ready = 1'b0;
      drive(1, 8'h5A, 1'b0, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (m_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_mid_sync", found, 1);
      check("rst_mid_m_data", m_data, 8'h5A);
      tick();
      rst = 1'b1;
      drive(1, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check("rst_mid_s0_ready", s0_ready, 0);
      check("rst_mid_s1_ready", s1_ready, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_m_valid", m_valid, 0);
      check("rst_mid_grant", grant, 0);
      check("rst_mid_rel_s0_ready", s0_ready, 0);
      check("rst_mid_rel_s1_ready", s1_ready, 0);
      tick();
      m_ready = 1'b1;

      // Pointer restored by reset: requester 0 wins the tie again
      hist.delete();
      expect_pkt(32'h0000_0091, 1);
      expect_pkt(32'h0000_0092, 1);
      fork
         send_pkt(0, 32'h0000_0091, 1, 1, 50);
         send_pkt(1, 32'h0000_0092, 1, 1, 50);
      join
      repeat (4) tick();
      check_hist("rst_tie_grant", 16'h0021, 4);

      check("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
